// File: rtl/top_main_pkg.sv
// Shared widths and write-source encodings for the datapath storage block.
package top_main_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 10;
  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int REG_DEPTH = 1 << ADDR_W;

  typedef enum logic {
    MEM_SRC_EXT  = 1'b0,
    MEM_SRC_REG1 = 1'b1
  } mem_src_e;

  typedef enum logic {
    REG_SRC_MEM = 1'b0,
    REG_SRC_EXT = 1'b1
  } reg_src_e;
endpackage

// File: rtl/top_main_if.sv
// Control-unit facing bus: addresses, write data, enable, selects, read data.
interface top_main_if;
  import top_main_pkg::*;

  logic [ADDR_W-1:0] address_mem;
  logic [ADDR_W-1:0] address_reg;
  logic [ADDR_W-1:0] address_reg1;
  logic [ADDR_W-1:0] address_reg2;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_in_reg;
  logic              enable;
  logic              memory_input_selection;
  logic              reg_input_selection;
  logic [DATA_W-1:0] data_mem;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] data_reg1;
  logic [DATA_W-1:0] data_reg2;

  modport master (
    output address_mem, address_reg, address_reg1, address_reg2,
    output data_in, data_in_reg, enable,
    output memory_input_selection, reg_input_selection,
    input  data_mem, data_reg, data_reg1, data_reg2
  );

  modport slave (
    input  address_mem, address_reg, address_reg1, address_reg2,
    input  data_in, data_in_reg, enable,
    input  memory_input_selection, reg_input_selection,
    output data_mem, data_reg, data_reg1, data_reg2
  );
endinterface

// File: rtl/top_main_regfile_3r1w.sv
// 3-read/1-write register file, combinational reads, sync clear.
// REG_ZERO_HARDWIRE_EN: register 0 reads 0 and ignores writes.
module regfile_3r1w
  import top_main_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] regs [REG_DEPTH];
  logic              wr_ok;

`ifdef REG_ZERO_HARDWIRE_EN
  assign wr_ok  = we && (waddr != '0);
  assign rdata0 = (raddr0 == '0) ? '0 : regs[raddr0];
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
`else
  assign wr_ok  = we;
  assign rdata0 = regs[raddr0];
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end
endmodule

// File: rtl/top_main_core.sv
// Data memory + register file with load/store write muxes.
// Optional: REG_ZERO_HARDWIRE_EN (register 0 hardwired to zero).
module top_main_core
  import top_main_pkg::*;
(
  input  logic clk,
  input  logic rst,
  top_main_if.slave bus
);
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] reg_wdata;
  mem_src_e          mem_src;
  reg_src_e          reg_src;

  assign mem_src = mem_src_e'(bus.memory_input_selection);
  assign reg_src = reg_src_e'(bus.reg_input_selection);

  assign bus.data_mem = mem[bus.address_mem];

  // Both muxes see pre-edge read data, so load+store swaps cleanly.
  always_comb begin
    mem_wdata = bus.data_in;
    reg_wdata = bus.data_mem;
    unique case (mem_src)
      MEM_SRC_EXT:  mem_wdata = bus.data_in;
      MEM_SRC_REG1: mem_wdata = bus.data_reg1;
    endcase
    unique case (reg_src)
      REG_SRC_MEM: reg_wdata = bus.data_mem;
      REG_SRC_EXT: reg_wdata = bus.data_in_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++)
        mem[i] <= '0;
    end else if (bus.enable) begin
      mem[bus.address_mem] <= mem_wdata;
    end
  end

  regfile_3r1w u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.enable),
    .waddr  (bus.address_reg),
    .wdata  (reg_wdata),
    .raddr0 (bus.address_reg),
    .raddr1 (bus.address_reg1),
    .raddr2 (bus.address_reg2),
    .rdata0 (bus.data_reg),
    .rdata1 (bus.data_reg1),
    .rdata2 (bus.data_reg2)
  );
endmodule

// File: tb/tb_top_main_core.sv
// Self-checking bench for top_main_core: directed cases then random ops
// against an array-based model of memory and register file.
module tb_top_main_core;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mm [1024];
  logic [31:0] rm [1024];

  top_main_if bus ();

  top_main_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_reg(input logic [9:0] a);
`ifdef REG_ZERO_HARDWIRE_EN
    if (a == 10'd0) return 32'd0;
`endif
    return rm[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [9:0] am, input logic [9:0] ar,
                       input logic [9:0] ar1, input logic [9:0] ar2,
                       input logic [31:0] din, input logic [31:0] dinr,
                       input logic en, input logic ms, input logic rs,
                       input logic r);
    bus.address_mem            = am;
    bus.address_reg            = ar;
    bus.address_reg1           = ar1;
    bus.address_reg2           = ar2;
    bus.data_in                = din;
    bus.data_in_reg            = dinr;
    bus.enable                 = en;
    bus.memory_input_selection = ms;
    bus.reg_input_selection    = rs;
    rst                        = r;
    #1;
  endtask

  task automatic check_reads(input string tag);
    chk({tag, "_mem"},  bus.data_mem,  mm[bus.address_mem]);
    chk({tag, "_reg"},  bus.data_reg,  rd_reg(bus.address_reg));
    chk({tag, "_reg1"}, bus.data_reg1, rd_reg(bus.address_reg1));
    chk({tag, "_reg2"}, bus.data_reg2, rd_reg(bus.address_reg2));
  endtask

  // Apply one rising edge to the model using pre-edge values.
  task automatic tick();
    logic [31:0] mv, rv;
    logic [9:0]  am, ar;
    logic        do_w, do_r;
    am   = bus.address_mem;
    ar   = bus.address_reg;
    mv   = bus.memory_input_selection ? rd_reg(bus.address_reg1)
                                      : bus.data_in;
    rv   = bus.reg_input_selection ? bus.data_in_reg : mm[am];
    do_w = bus.enable && !rst;
    do_r = rst;
    @(posedge clk);
    if (do_r) begin
      for (int i = 0; i < 1024; i++) begin
        mm[i] = '0;
        rm[i] = '0;
      end
    end else if (do_w) begin
      mm[am] = mv;
`ifdef REG_ZERO_HARDWIRE_EN
      if (ar != 10'd0) rm[ar] = rv;
`else
      rm[ar] = rv;
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mm[i] = 'x;
      rm[i] = 'x;
    end
    @(negedge clk);

    // Reset clears everything.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(10'd17, 10'd300, 10'd1023, 10'd5, 0, 0, 0, 0, 0, 0);
    chk("rst_mem",  bus.data_mem,  32'd0);
    chk("rst_reg",  bus.data_reg,  32'd0);
    chk("rst_reg1", bus.data_reg1, 32'd0);
    chk("rst_reg2", bus.data_reg2, 32'd0);

    // External memory write; old value visible until the edge.
    drive(10'd0, 10'd600, 10'd601, 10'd602, 32'd29839, 32'd7, 1, 0, 1, 0);
    chk("mem0_before", bus.data_mem, 32'd0);
    tick();
    drive(10'd0, 10'd1, 10'd1, 10'd1, 0, 0, 0, 0, 0, 0);
    chk("mem0_after", bus.data_mem, 32'd29839);

    // External register write, seen on all three read ports.
    drive(10'd700, 10'd5, 10'd5, 10'd5, 0, 32'hDEADBEEF, 1, 0, 1, 0);
    chk("r5_before", bus.data_reg, 32'd0);
    tick();
    drive(10'd700, 10'd5, 10'd5, 10'd5, 0, 0, 0, 1, 0, 0);
    chk("r5_p0", bus.data_reg,  32'hDEADBEEF);
    chk("r5_p1", bus.data_reg1, 32'hDEADBEEF);
    chk("r5_p2", bus.data_reg2, 32'hDEADBEEF);

    // Load: mem[3] -> reg[7].
    drive(10'd3, 10'd701, 10'd0, 10'd0, 32'h1234, 0, 1, 0, 1, 0);
    tick();
    drive(10'd3, 10'd7, 10'd0, 10'd0, 0, 32'hFFFF, 1, 0, 0, 0);
    tick();
    drive(10'd3, 10'd7, 10'd7, 10'd7, 0, 0, 0, 0, 0, 0);
    chk("load_r7", bus.data_reg, 32'h1234);

    // Store: reg[2] -> mem[9].
    drive(10'd702, 10'd2, 10'd0, 10'd0, 0, 32'hA5A5A5A5, 1, 0, 1, 0);
    tick();
    drive(10'd9, 10'd703, 10'd2, 10'd0, 32'h1111, 32'd0, 1, 1, 1, 0);
    tick();
    drive(10'd9, 10'd2, 10'd2, 10'd2, 0, 0, 0, 0, 0, 0);
    chk("store_m9", bus.data_mem, 32'hA5A5A5A5);

    // Simultaneous load+store on the same register: swap.
    drive(10'd9, 10'd5, 10'd5, 10'd0, 0, 0, 1, 1, 0, 0);
    tick();
    drive(10'd9, 10'd5, 10'd5, 10'd5, 0, 0, 0, 0, 0, 0);
    chk("swap_mem", bus.data_mem, 32'hDEADBEEF);
    chk("swap_reg", bus.data_reg, 32'hA5A5A5A5);

    // Top address boundary.
    drive(10'd1023, 10'd1023, 10'd0, 10'd0, 32'hCAFE0001, 32'hCAFE0002,
          1, 0, 1, 0);
    tick();
    drive(10'd1023, 10'd1023, 10'd1023, 10'd0, 0, 0, 0, 0, 0, 0);
    chk("top_mem", bus.data_mem, 32'hCAFE0001);
    chk("top_reg", bus.data_reg, 32'hCAFE0002);

    // Register 0 write behaviour depends on configuration.
    drive(10'd704, 10'd0, 10'd0, 10'd0, 0, 32'h55, 1, 0, 1, 0);
    tick();
    drive(10'd704, 10'd0, 10'd0, 10'd0, 0, 0, 0, 0, 0, 0);
`ifdef REG_ZERO_HARDWIRE_EN
    chk("r0_write", bus.data_reg, 32'd0);
`else
    chk("r0_write", bus.data_reg, 32'h55);
`endif

    // Reset with enable on the same edge wins.
    drive(10'd9, 10'd5, 10'd1023, 10'd7, 32'h77, 32'h88, 1, 0, 1, 1);
    tick();
    drive(10'd9, 10'd5, 10'd1023, 10'd7, 0, 0, 0, 0, 0, 0);
    chk("rst_en_mem",  bus.data_mem,  32'd0);
    chk("rst_en_reg",  bus.data_reg,  32'd0);
    chk("rst_en_reg1", bus.data_reg1, 32'd0);
    chk("rst_en_reg2", bus.data_reg2, 32'd0);

    // Random operations over a small address window plus the top word.
    for (int n = 0; n < 400; n++) begin
      logic [9:0] a [4];
      for (int k = 0; k < 4; k++)
        a[k] = ($urandom_range(0, 9) == 0) ? 10'd1023
                                           : 10'($urandom_range(0, 7));
      drive(a[0], a[1], a[2], a[3], $urandom, $urandom,
            1'($urandom_range(0, 3) != 0), 1'($urandom),
            1'($urandom), 1'($urandom_range(0, 49) == 0));
      check_reads("rnd");
      tick();
    end
    drive(0, 1, 2, 3, 0, 0, 0, 0, 0, 0);
    check_reads("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
